// File: rtl/coor_gen_rr_if.sv
// Engine-side bus of the coordinate generator.
//   cdones        : per-engine "ready for work" flags (engines -> generator)
//   clatch_en     : word valid for engine cengine_addr (generator -> engines)
//   cengine_addr  : target engine index
//   cword2engines : {x, y, re, im} of the issued pixel
// master = generator side, slave = engine side.
interface coor_gen_rr_if #(
  parameter int NUM_PROC = 4,
  parameter int ADDR_W   = 2,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int CW       = 32
) ();
  logic [NUM_PROC-1:0]       cdones;
  logic                      clatch_en;
  logic [ADDR_W-1:0]         cengine_addr;
  logic [XW+YW+2*CW-1:0]     cword2engines;

  modport master (input cdones, output clatch_en, cengine_addr, cword2engines);
  modport slave  (output cdones, input clatch_en, cengine_addr, cword2engines);
endinterface

// File: rtl/coor_gen_rr.sv
// Mandelbrot coordinate generator with round-robin engine dispatch.
// Scans an H_RES x V_RES grid column-major (y inner) and issues {x, y, re, im}
// to a ready engine each cycle, re = x0 + x*step, im = y0 - y*step (Q8.24).
// Ports:
//   cclk, creset       : clock, synchronous active-high reset
//   eng                : engine bus (cdones in; clatch_en/cengine_addr/cword2engines out)
//   cfg_x0/y0/step     : pan/zoom values, captured into shadow on cfg_load
//   start              : request one frame (ignored while running)
//   busy               : frame in progress
//   frame_start        : one-cycle pulse when a frame is accepted
//   frame_done         : one-cycle pulse after the last pixel is issued
//
// state | meaning
// IDLE  | waiting for start; no issues
// RUN   | scanning pixels, one issue per cycle when an engine is eligible
module coor_gen_rr #(
  parameter int NUM_PROC = 4,
  parameter int ADDR_W   = 2,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int CW       = 32
) (
  input  logic                 cclk,
  input  logic                 creset,
  coor_gen_rr_if.master        eng,
  input  logic [CW-1:0]        cfg_x0,
  input  logic [CW-1:0]        cfg_y0,
  input  logic [CW-1:0]        cfg_step,
  input  logic                 cfg_load,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_start,
  output logic                 frame_done
);

  localparam int NSLOT = 2**ADDR_W;
  localparam logic [CW-1:0] DEF_X0   = CW'(32'hFE00_0000);
  localparam logic [CW-1:0] DEF_Y0   = CW'(32'h0120_0000);
  localparam logic [CW-1:0] DEF_STEP = CW'(32'h0001_3333);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CW-1:0]     re, im;
  logic [ADDR_W-1:0] ptr;
  logic              done_pend;
  logic [CW-1:0]     sh_x0, sh_y0, sh_step;
  logic [CW-1:0]     act_y0, act_step;

  logic [NSLOT-1:0]  last_mask, elig;
  logic              found;
  logic [ADDR_W-1:0] grant, idx, ptr_next;
  logic              x_last, y_last, accept;
  logic [CW-1:0]     st_x0, st_y0, st_step;

  // The engine latched this cycle may still show cdones high, so mask it.
  always_comb begin
    last_mask = '0;
    if (eng.clatch_en) last_mask[eng.cengine_addr] = 1'b1;
    elig = NSLOT'(eng.cdones) & ~last_mask;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      idx = ADDR_W'((int'(ptr) + i) % NUM_PROC);
      if (elig[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    ptr_next = ADDR_W'((int'(grant) + 1) % NUM_PROC);
  end

  assign x_last = (x == XW'(H_RES - 1));
  assign y_last = (y == YW'(V_RES - 1));
  // busy stays high through the done cycle, which keeps a start from
  // overlapping the frame_done pulse.
  assign accept = (state == IDLE) && start && !busy;
  // A cfg_load coincident with start takes effect for that frame.
  assign st_x0   = cfg_load ? cfg_x0   : sh_x0;
  assign st_y0   = cfg_load ? cfg_y0   : sh_y0;
  assign st_step = cfg_load ? cfg_step : sh_step;

  always_ff @(posedge cclk) begin
    if (creset) begin
      state             <= IDLE;
      x                 <= '0;
      y                 <= '0;
      re                <= '0;
      im                <= '0;
      ptr               <= '0;
      done_pend         <= 1'b0;
      busy              <= 1'b0;
      frame_start       <= 1'b0;
      frame_done        <= 1'b0;
      eng.clatch_en     <= 1'b0;
      eng.cengine_addr  <= '0;
      eng.cword2engines <= '0;
      sh_x0             <= DEF_X0;
      sh_y0             <= DEF_Y0;
      sh_step           <= DEF_STEP;
      act_y0            <= DEF_Y0;
      act_step          <= DEF_STEP;
    end else begin
      frame_start   <= 1'b0;
      frame_done    <= done_pend;
      eng.clatch_en <= 1'b0;
      if (done_pend) begin
        done_pend <= 1'b0;
        busy      <= 1'b0;
      end
      if (cfg_load) begin
        sh_x0   <= cfg_x0;
        sh_y0   <= cfg_y0;
        sh_step <= cfg_step;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            act_y0      <= st_y0;
            act_step    <= st_step;
            re          <= st_x0;
            im          <= st_y0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (found) begin
            eng.clatch_en     <= 1'b1;
            eng.cengine_addr  <= grant;
            eng.cword2engines <= {x, y, re, im};
            ptr               <= ptr_next;
            if (y_last) begin
              y  <= '0;
              im <= act_y0;
              x  <= x + XW'(1);
              re <= re + act_step;
              if (x_last) begin
                state     <= IDLE;
                done_pend <= 1'b1;
              end
            end else begin
              y  <= y + YW'(1);
              im <= im - act_step;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coor_gen_rr.sv
module tb_coor_gen_rr;
  localparam int HA = 7, VA = 10;
  localparam int HB = 6, VB = 5;
  localparam int WW = 10 + 9 + 64;
  localparam logic [31:0] DX0 = 32'hFE00_0000;
  localparam logic [31:0] DY0 = 32'h0120_0000;
  localparam logic [31:0] DST = 32'h0001_3333;

  bit clk;
  logic creset, start_a, start_b, cfg_load;
  logic [31:0] cfg_x0, cfg_y0, cfg_step;
  logic busy_a, fs_a, fd_a, busy_b, fs_b, fd_b;

  coor_gen_rr_if #(.NUM_PROC(4), .ADDR_W(2)) bus_a ();
  coor_gen_rr_if #(.NUM_PROC(1), .ADDR_W(1)) bus_b ();

  coor_gen_rr #(.NUM_PROC(4), .ADDR_W(2), .H_RES(HA), .V_RES(VA)) dut_a (
    .cclk(clk), .creset(creset), .eng(bus_a),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_step(cfg_step), .cfg_load(cfg_load),
    .start(start_a), .busy(busy_a), .frame_start(fs_a), .frame_done(fd_a));

  coor_gen_rr #(.NUM_PROC(1), .ADDR_W(1), .H_RES(HB), .V_RES(VB)) dut_b (
    .cclk(clk), .creset(creset), .eng(bus_b),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_step(cfg_step), .cfg_load(cfg_load),
    .start(start_b), .busy(busy_b), .frame_start(fs_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_word(input int xx, input int yy,
                                            input logic [31:0] x0, input logic [31:0] y0,
                                            input logic [31:0] st);
    logic [31:0] r, i;
    r = x0 + 32'(xx) * st;
    i = y0 - 32'(yy) * st;
    return {10'(xx), 9'(yy), r, i};
  endfunction

  // Reference model for instance A: pixel index p, x = p / VA, y = p % VA.
  bit          m_run, m_busy, m_pend;
  int          m_p, m_ptr;
  bit          e_en, e_fs, e_fd;
  logic [1:0]  e_addr = '0;
  logic [WW-1:0] e_word = '0;
  logic [31:0] s_x0 = DX0, s_y0 = DY0, s_st = DST;
  logic [31:0] a_x0 = DX0, a_y0 = DY0, a_st = DST;

  always @(posedge clk) begin
    bit acc;
    int g;
    logic [3:0] msk, elig;
    if (creset) begin
      m_run = 0; m_busy = 0; m_pend = 0; m_p = 0; m_ptr = 0;
      e_en = 0; e_fs = 0; e_fd = 0; e_addr = '0; e_word = '0;
      s_x0 = DX0; s_y0 = DY0; s_st = DST;
      a_x0 = DX0; a_y0 = DY0; a_st = DST;
    end else begin
      acc  = !m_run && start_a && !m_busy;
      msk  = e_en ? (4'b0001 << e_addr) : 4'b0000;
      e_fs = acc;
      e_fd = m_pend;
      if (m_pend) begin m_busy = 0; m_pend = 0; end
      e_en = 0;
      if (m_run) begin
        elig = bus_a.cdones & ~msk;
        g = -1;
        for (int k = 0; k < 4; k++)
          if (g < 0 && elig[2'((m_ptr + k) % 4)]) g = (m_ptr + k) % 4;
        if (g >= 0) begin
          e_en   = 1;
          e_addr = 2'(g);
          e_word = mk_word(m_p / VA, m_p % VA, a_x0, a_y0, a_st);
          m_ptr  = (g + 1) % 4;
          m_p++;
          if (m_p == HA * VA) begin m_run = 0; m_pend = 1; end
        end
      end
      if (acc) begin
        if (cfg_load) begin a_x0 = cfg_x0; a_y0 = cfg_y0; a_st = cfg_step; end
        else begin a_x0 = s_x0; a_y0 = s_y0; a_st = s_st; end
        m_run = 1; m_busy = 1; m_p = 0;
      end
      if (cfg_load) begin s_x0 = cfg_x0; s_y0 = cfg_y0; s_st = cfg_step; end
    end
  end

  // Compare process: instance A against the model every cycle; instance B
  // against a pixel-index scoreboard while its frame is being monitored.
  bit chk_on, b_mon, b_prev_en;
  int b_cnt, b_fd_cnt;
  logic [WW-1:0] b_last = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_ctl", {bus_a.clatch_en, busy_a, fs_a, fd_a}, {e_en, m_busy, e_fs, e_fd});
      if (e_en) begin
        chk("a_addr", bus_a.cengine_addr, e_addr);
        chk("a_word", bus_a.cword2engines, e_word);
      end
      if (b_mon && bus_b.clatch_en) begin
        chk("b_alt", b_prev_en, 0);
        chk("b_addr", bus_b.cengine_addr, 0);
        chk("b_word", bus_b.cword2engines, mk_word(b_cnt / VB, b_cnt % VB, DX0, DY0, DST));
        b_cnt++;
        b_last = bus_b.cword2engines;
      end
      if (b_mon && fd_b) b_fd_cnt++;
      b_prev_en = bus_b.clatch_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    creset = 1;
    repeat (n) tick();
    creset = 0;
  endtask

  task automatic pulse_start_a();
    start_a = 1;
    tick();
    start_a = 0;
  endtask

  task automatic wait_fd_a(input int budget, input string nm);
    int n = 0;
    while (fd_a !== 1'b1 && n < budget) begin tick(); n++; end
    chk(nm, fd_a === 1'b1, 1);
  endtask

  task automatic wait_pix_a(input int xx, input int yy, input int budget, input string nm);
    int n = 0;
    while (!(bus_a.clatch_en === 1'b1 && bus_a.cword2engines[82:73] == 10'(xx)
             && bus_a.cword2engines[72:64] == 9'(yy)) && n < budget) begin
      tick(); n++;
    end
    chk(nm, n < budget, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fdc, n;
    logic [1:0] seq [4];
    creset = 1; start_a = 0; start_b = 0; cfg_load = 0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_step = '0;
    bus_a.cdones = '0; bus_b.cdones = '0;
    tick();
    chk_on = 1;
    tick();
    creset = 0;

    chk("rst_a", {bus_a.clatch_en, bus_a.cengine_addr, busy_a, fs_a, fd_a}, 0);
    chk("rst_a_word", bus_a.cword2engines, 0);
    chk("rst_b", {bus_b.clatch_en, busy_b, fs_b, fd_b, bus_b.cword2engines}, 0);

    // Full frame on the single-engine instance with cdones held high.
    bus_b.cdones = 1'b1;
    b_mon = 1;
    start_b = 1;
    tick();
    start_b = 0;
    chk("b_fs", {fs_b, busy_b}, 2'b11);
    n = 0;
    while (fd_b !== 1'b1 && n < 200) begin tick(); n++; end
    chk("b_done_seen", fd_b === 1'b1, 1);
    chk("b_busy_done", busy_b, 0);
    repeat (4) tick();
    b_mon = 0;
    chk("b_issue_cnt", b_cnt, HB * VB);
    chk("b_fd_cnt", b_fd_cnt, 1);
    chk("b_last", b_last, {10'd5, 9'd4, 32'hFE05_FFFF, 32'h011B_3334});

    // Round robin with all engines ready.
    pulse_start_a();
    chk("a_fs", {fs_a, busy_a}, 2'b11);
    bus_a.cdones = 4'b1111;
    tick();
    chk("a_first_word", bus_a.cword2engines, {10'd0, 9'd0, 32'hFE00_0000, 32'h0120_0000});
    seq[0] = bus_a.cengine_addr;
    for (int i = 1; i < 4; i++) begin tick(); seq[i] = bus_a.cengine_addr; end
    chk("rr_1111", {seq[0], seq[1], seq[2], seq[3]}, {2'd0, 2'd1, 2'd2, 2'd3});
    tick();
    chk("rr_wrap", {bus_a.clatch_en, bus_a.cengine_addr}, {1'b1, 2'd0});

    // Two ready engines, then a pause mid-column.
    do_reset(2);
    pulse_start_a();
    bus_a.cdones = 4'b1001;
    for (int i = 0; i < 4; i++) begin tick(); seq[i] = bus_a.cengine_addr; end
    chk("rr_1001", {seq[0], seq[1], seq[2], seq[3]}, {2'd0, 2'd3, 2'd0, 2'd3});
    bus_a.cdones = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_en", bus_a.clatch_en, 0);
    end
    bus_a.cdones = 4'b1001;
    tick();
    chk("resume", {bus_a.clatch_en, bus_a.cengine_addr, bus_a.cword2engines},
        {1'b1, 2'd0, 10'd0, 9'd4, 32'hFE00_0000, 32'h011B_3334});

    // Config loaded mid-frame applies to the next frame only.
    bus_a.cdones = 4'b1111;
    repeat (2) tick();
    cfg_x0 = 32'h0; cfg_y0 = 32'h0; cfg_step = 32'h0001_0000;
    cfg_load = 1;
    tick();
    cfg_load = 0;
    wait_fd_a(300, "cfg_frame_done");
    tick();
    pulse_start_a();
    tick();
    chk("cfg_first", {bus_a.clatch_en, bus_a.cword2engines}, {1'b1, 83'd0});
    wait_pix_a(1, 2, 100, "cfg_pix12_seen");
    chk("cfg_pix12", bus_a.cword2engines[63:0], {32'h0001_0000, 32'hFFFE_0000});

    // Reset mid-frame at pixel (5,7).
    wait_pix_a(5, 7, 100, "pix57_seen");
    do_reset(1);
    chk("midrst", {bus_a.clatch_en, bus_a.cengine_addr, busy_a, fs_a, fd_a}, 0);
    chk("midrst_word", bus_a.cword2engines, 0);
    fdc = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (fd_a === 1'b1) fdc++; end
    chk("midrst_no_fd", fdc, 0);
    pulse_start_a();
    tick();
    chk("restart", {bus_a.clatch_en, bus_a.cword2engines},
        {1'b1, 10'd0, 9'd0, 32'hFE00_0000, 32'h0120_0000});
    wait_fd_a(300, "restart_done");

    // Randomized frames: random readiness, config reloads, stray starts.
    for (int f = 0; f < 5; f++) begin
      tick();
      pulse_start_a();
      n = 0;
      while (fd_a !== 1'b1 && n < 600) begin
        bus_a.cdones = 4'($urandom);
        cfg_load = ($urandom_range(0, 15) == 0);
        if (cfg_load) begin
          cfg_x0 = $urandom; cfg_y0 = $urandom; cfg_step = $urandom;
        end
        start_a = ($urandom_range(0, 7) == 0);
        tick();
        n++;
      end
      cfg_load = 0;
      start_a = 0;
      chk("rnd_done", fd_a === 1'b1, 1);
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
